// File: rtl/dvs_event_packetizer.sv
// DVS event packetizer: pops {x, y, pol, ts} events and emits delta-time RAVENS
// packets, preceded by TS_HI/TS_LO sync words when the delta cannot be encoded.
module dvs_event_packetizer #(
   parameter int X_BITS   = 9,
   parameter int Y_BITS   = 9,
   parameter int TS_BITS  = 45,
   parameter int PKT_BITS = 32,
   parameter int DT_BITS  = 12,
   localparam int EVENT_BITS = X_BITS + Y_BITS + 1 + TS_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [EVENT_BITS-1:0] event_in,
   input  logic                  event_valid,
   output logic                  event_ready,
   input  logic                  resync_req,
   output logic [PKT_BITS-1:0]   pkt_out,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic                  sync_pending
);

   localparam int LO_BITS = 22;
   localparam int HI_BITS = TS_BITS - LO_BITS;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SEND_HI  = 2'd1;
   localparam logic [1:0] ST_SEND_LO  = 2'd2;
   localparam logic [1:0] ST_SEND_EVT = 2'd3;

   function automatic logic [PKT_BITS-1:0] fmt_ts_hi(input logic [TS_BITS-1:0] ts);
      return {2'b10, {(PKT_BITS-2-HI_BITS){1'b0}}, ts[TS_BITS-1:LO_BITS]};
   endfunction

   function automatic logic [PKT_BITS-1:0] fmt_ts_lo(input logic [TS_BITS-1:0] ts);
      return {2'b11, {(PKT_BITS-2-LO_BITS){1'b0}}, ts[LO_BITS-1:0]};
   endfunction

   function automatic logic [PKT_BITS-1:0] fmt_event(input logic              pol,
                                                     input logic [Y_BITS-1:0]  y,
                                                     input logic [X_BITS-1:0]  x,
                                                     input logic [DT_BITS-1:0] dt);
      return {1'b0, pol, y, x, dt};
   endfunction

   logic [1:0]          state_r;
   logic [PKT_BITS-1:0] pkt_out_r;
   logic                pkt_valid_r;
   logic [PKT_BITS-1:0] lo_word_r;
   logic [PKT_BITS-1:0] evt_word_r;
   logic [TS_BITS-1:0]  last_ts_r;
   logic                sync_pending_r;
   logic                resync_hold_r;

   logic [X_BITS-1:0]   ev_x_s;
   logic [Y_BITS-1:0]   ev_y_s;
   logic                ev_pol_s;
   logic [TS_BITS-1:0]  ev_ts_s;
   logic [TS_BITS-1:0]  delta_s;
   logic                sync_needed_s;
   logic [DT_BITS-1:0]  dt_s;
   logic                lo_exit_s;
   logic                in_sync_s;

   // Field split, delta computation and sync decision for the event at the FIFO head
   always_comb begin
      ev_x_s        = event_in[EVENT_BITS-1 -: X_BITS];
      ev_y_s        = event_in[TS_BITS+1 +: Y_BITS];
      ev_pol_s      = event_in[TS_BITS];
      ev_ts_s       = event_in[TS_BITS-1:0];
      delta_s       = ev_ts_s - last_ts_r;
      sync_needed_s = sync_pending_r | resync_req | (ev_ts_s < last_ts_r) |
                      (delta_s[TS_BITS-1:DT_BITS] != {(TS_BITS-DT_BITS){1'b0}});
      if (sync_needed_s) begin
         dt_s = {DT_BITS{1'b0}};
      end else begin
         dt_s = delta_s[DT_BITS-1:0];
      end
      lo_exit_s = (state_r == ST_SEND_LO) & pkt_ready;
      in_sync_s = (state_r == ST_SEND_HI) | (state_r == ST_SEND_LO);
   end

   // Packet sequencing FSM with registered packet output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         pkt_out_r   <= {PKT_BITS{1'b0}};
         pkt_valid_r <= 1'b0;
         lo_word_r   <= {PKT_BITS{1'b0}};
         evt_word_r  <= {PKT_BITS{1'b0}};
         last_ts_r   <= {TS_BITS{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (event_valid) begin
                  last_ts_r   <= ev_ts_s;
                  lo_word_r   <= fmt_ts_lo(ev_ts_s);
                  evt_word_r  <= fmt_event(ev_pol_s, ev_y_s, ev_x_s, dt_s);
                  pkt_valid_r <= 1'b1;
                  if (sync_needed_s) begin
                     pkt_out_r <= fmt_ts_hi(ev_ts_s);
                     state_r   <= ST_SEND_HI;
                  end else begin
                     pkt_out_r <= fmt_event(ev_pol_s, ev_y_s, ev_x_s, dt_s);
                     state_r   <= ST_SEND_EVT;
                  end
               end
            end
            ST_SEND_HI: begin
               if (pkt_ready) begin
                  pkt_out_r <= lo_word_r;
                  state_r   <= ST_SEND_LO;
               end
            end
            ST_SEND_LO: begin
               if (pkt_ready) begin
                  pkt_out_r <= evt_word_r;
                  state_r   <= ST_SEND_EVT;
               end
            end
            ST_SEND_EVT: begin
               if (pkt_ready) begin
                  pkt_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               pkt_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Sync tracking; a resync seen while sync words are in flight survives their completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_pending_r <= 1'b1;
         resync_hold_r  <= 1'b0;
      end else if (lo_exit_s) begin
         sync_pending_r <= resync_hold_r | resync_req;
         resync_hold_r  <= 1'b0;
      end else if (resync_req) begin
         sync_pending_r <= 1'b1;
         resync_hold_r  <= resync_hold_r | in_sync_s;
      end else begin
         sync_pending_r <= sync_pending_r;
         resync_hold_r  <= resync_hold_r;
      end
   end

   assign event_ready  = (state_r == ST_IDLE);
   assign pkt_out      = pkt_out_r;
   assign pkt_valid    = pkt_valid_r;
   assign sync_pending = sync_pending_r;

endmodule

// File: tb/tb_dvs_event_packetizer.sv
// Bench for dvs_event_packetizer: directed scenarios plus randomized traffic
// compared every cycle against a packet-queue reference model.
module tb_dvs_event_packetizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] event_in;
   logic        event_valid;
   logic        event_ready;
   logic        resync_req;
   logic [31:0] pkt_out;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        sync_pending;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] seen_q[$];
   logic [44:0] last_m;
   bit          pending_m;
   bit          defer_m;

   dvs_event_packetizer dut (
      .clk         (clk),
      .rst         (rst),
      .event_in    (event_in),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .resync_req  (resync_req),
      .pkt_out     (pkt_out),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .sync_pending(sync_pending)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      last_m    = 45'd0;
      pending_m = 1'b1;
      defer_m   = 1'b0;
   endtask

   function automatic logic [63:0] mk_event(input int x, input int y, input int pol, input logic [44:0] ts);
      logic [8:0] xv;
      logic [8:0] yv;
      xv = 9'(x);
      yv = 9'(y);
      return {xv, yv, pol[0], ts};
   endfunction

   // One clock: check outputs against the model, then advance the model by this cycle's handshakes
   task automatic cycle();
      bit          busy, accept, hs, lo_exit, in_sync, need_sync;
      logic [31:0] w, xe, ye, pe, dt;
      logic [44:0] ts, d;
      @(negedge clk);
      busy = (exp_q.size() != 0);
      check_val("event_ready", event_ready, !busy);
      check_val("pkt_valid", pkt_valid, busy);
      check_val("sync_pending", sync_pending, pending_m);
      if (busy) check_val("pkt_out", pkt_out, exp_q[0]);
      accept  = event_valid && !busy;
      hs      = pkt_ready && busy;
      in_sync = busy && exp_q[0][31];
      lo_exit = hs && (exp_q[0][31:30] == 2'b11);
      if (hs) begin
         w = exp_q.pop_front();
         seen_q.push_back(pkt_out);
      end
      if (lo_exit) begin
         pending_m = defer_m | resync_req;
         defer_m   = 1'b0;
      end else if (resync_req) begin
         pending_m = 1'b1;
         if (in_sync) defer_m = 1'b1;
      end
      if (accept) begin
         ts = event_in[44:0];
         xe = 32'(event_in[63:55]);
         ye = 32'(event_in[54:46]);
         pe = 32'(event_in[45]);
         d  = ts - last_m;
         need_sync = pending_m || resync_req || (ts < last_m) || (d > 45'd4095);
         dt = need_sync ? 32'd0 : 32'(d);
         if (need_sync) begin
            exp_q.push_back(32'h8000_0000 | 32'(ts >> 22));
            exp_q.push_back(32'hC000_0000 | 32'(ts & 45'h3F_FFFF));
         end
         exp_q.push_back((pe << 30) | (ye << 21) | (xe << 12) | dt);
         last_m = ts;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      event_valid = 1'b0;
      resync_req  = 1'b0;
      pkt_ready   = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
      cycle();
   endtask

   task automatic send_event(input int x, input int y, input int pol, input logic [44:0] ts);
      seen_q.delete();
      event_in    = mk_event(x, y, pol, ts);
      event_valid = 1'b1;
      pkt_ready   = 1'b1;
      cycle();
      drain();
   endtask

   task automatic expect_seen(input string tag, input int n,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      check_val({tag, "_count"}, seen_q.size(), n);
      if (seen_q.size() == n) begin
         check_val({tag, "_w0"}, seen_q[0], w0);
         if (n > 1) check_val({tag, "_w1"}, seen_q[1], w1);
         if (n > 2) check_val({tag, "_w2"}, seen_q[2], w2);
      end
   endtask

   initial begin
      logic [44:0] ts_r;
      int          mode;
      rst         = 1'b1;
      event_in    = 64'd0;
      event_valid = 1'b0;
      resync_req  = 1'b0;
      pkt_ready   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_pkt_valid", pkt_valid, 1'b0);
      check_val("rst_pkt_out", pkt_out, 32'd0);
      check_val("rst_event_ready", event_ready, 1'b1);
      check_val("rst_sync_pending", sync_pending, 1'b1);
      rst = 1'b0;
      cycle();

      // T1 first event always syncs
      send_event(5, 7, 1, 45'd100);
      expect_seen("t1", 3, 32'h8000_0000, 32'hC000_0064, 32'h40E0_5000);
      // T2 largest encodable delta
      send_event(345, 259, 0, 45'd4195);
      expect_seen("t2", 1, 32'h2075_9FFF, 32'd0, 32'd0);
      // T3 delta one beyond range
      send_event(1, 2, 0, 45'd8291);
      expect_seen("t3", 3, 32'h8000_0000, 32'hC000_2063, 32'h0040_1000);
      // T4 backwards timestamp
      send_event(0, 0, 1, 45'd50);
      expect_seen("t4", 3, 32'h8000_0000, 32'hC000_0032, 32'h4000_0000);

      // T5 stall in SEND_HI; another valid event waits unpopped
      seen_q.delete();
      event_in    = mk_event(3, 4, 0, 45'd60);
      event_valid = 1'b1;
      resync_req  = 1'b1;
      pkt_ready   = 1'b0;
      cycle();
      resync_req  = 1'b0;
      event_in    = mk_event(9, 9, 1, 45'd70);
      repeat (5) cycle();
      drain();
      expect_seen("t5", 3, 32'h8000_0000, 32'hC000_003C, 32'h0080_3000);

      // Resync during SEND_HI carries over to the next event
      seen_q.delete();
      event_in    = mk_event(1, 1, 0, 45'd80);
      event_valid = 1'b1;
      resync_req  = 1'b1;
      pkt_ready   = 1'b1;
      cycle();
      event_valid = 1'b0;
      cycle();
      resync_req  = 1'b0;
      drain();
      send_event(1, 1, 0, 45'd81);
      expect_seen("resync_hi", 3, 32'h8000_0000, 32'hC000_0051, 32'h0020_1000);

      // T6 reset in SEND_LO
      event_in    = mk_event(2, 2, 1, 45'd90);
      event_valid = 1'b1;
      resync_req  = 1'b1;
      pkt_ready   = 1'b1;
      cycle();
      event_valid = 1'b0;
      resync_req  = 1'b0;
      cycle();
      rst = 1'b1;
      #1;
      check_val("t6_rst_valid", pkt_valid, 1'b0);
      check_val("t6_rst_ready", event_ready, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_event(4, 4, 0, 45'd70);
      expect_seen("t6_post", 3, 32'h8000_0000, 32'hC000_0046, 32'h0080_4000);
      seen_q.delete();
      event_in    = mk_event(4, 4, 0, 45'd80);
      event_valid = 1'b1;
      cycle();
      event_valid = 1'b0;
      resync_req  = 1'b1;
      cycle();
      resync_req  = 1'b0;
      drain();
      expect_seen("t6_nosync", 1, 32'h0080_400A, 32'd0, 32'd0);
      send_event(4, 4, 0, 45'd90);
      expect_seen("t6_resync", 3, 32'h8000_0000, 32'hC000_005A, 32'h0080_4000);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         mode = $urandom_range(0, 9);
         if (mode <= 5)      ts_r = last_m + 45'($urandom_range(0, 4095));
         else if (mode == 6) ts_r = last_m + 45'($urandom_range(4094, 4097));
         else if (mode == 7) ts_r = last_m - 45'($urandom_range(1, 100));
         else if (mode == 8) ts_r = 45'({$urandom, $urandom});
         else                ts_r = last_m;
         event_in    = mk_event($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1), ts_r);
         event_valid = ($urandom_range(0, 3) != 0);
         resync_req  = ($urandom_range(0, 15) == 0);
         pkt_ready   = ($urandom_range(0, 9) < 7);
         cycle();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
